// File: rtl/m_seg_scanner_if.sv
// Load/display bundle for m_seg_scanner: the master supplies digits, the slave scans them out.
interface m_seg_scanner_if #(
  parameter int unsigned NDIG = 4
);
  logic                 load;
  logic [4*NDIG-1:0]    dat_in;
  logic [NDIG-1:0]      dp_in;
  logic                 pend;
  logic [3:0]           nib_o;
  logic                 dp_n;
  logic [NDIG-1:0]      dig_n;
  logic                 frame_tick;

  modport master (
    output load, dat_in, dp_in,
    input  pend, nib_o, dp_n, dig_n, frame_tick
  );

  modport slave (
    input  load, dat_in, dp_in,
    output pend, nib_o, dp_n, dig_n, frame_tick
  );
endinterface

// File: rtl/m_seg_scanner.sv
// Time-multiplexed common-anode 7-segment scan driver with frame-aligned value updates.
// Optional leading-zero suppression is enabled by defining LEAD_ZERO_BLANK_EN.
module m_seg_scanner #(
  parameter int unsigned NDIG  = 4,
  parameter int unsigned DIV   = 50000,
  parameter int unsigned BLANK = 16
) (
  input logic             clk,
  input logic             rst_n,
  m_seg_scanner_if.slave  scan_if
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IdxW = $clog2(NDIG);

  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [4*NDIG-1:0] disp_q, disp_d, shad_q, shad_d;
  logic [NDIG-1:0]   disp_dp_q, disp_dp_d, shad_dp_q, shad_dp_d;
  logic              pend_q, pend_d;

  logic cnt_wrap;
  logic fb;
  logic suppress;
  logic [NDIG-1:0] dig_n;

  assign cnt_wrap = (cnt_q == CntW'(DIV - 1));
  assign fb       = cnt_wrap && (idx_q == IdxW'(NDIG - 1));

  always_comb begin
    cnt_d     = cnt_wrap ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q;
    disp_d    = disp_q;
    disp_dp_d = disp_dp_q;
    shad_d    = shad_q;
    shad_dp_d = shad_dp_q;
    pend_d    = pend_q;

    if (cnt_wrap) begin
      idx_d = (idx_q == IdxW'(NDIG - 1)) ? '0 : idx_q + 1'b1;
    end

    // A load landing on the boundary goes straight to the display and drops any pending value.
    if (fb && scan_if.load) begin
      disp_d    = scan_if.dat_in;
      disp_dp_d = scan_if.dp_in;
      pend_d    = 1'b0;
    end else if (fb && pend_q) begin
      disp_d    = shad_q;
      disp_dp_d = shad_dp_q;
      pend_d    = 1'b0;
    end else if (scan_if.load) begin
      shad_d    = scan_if.dat_in;
      shad_dp_d = scan_if.dp_in;
      pend_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      disp_q    <= '0;
      disp_dp_q <= '0;
      shad_q    <= '0;
      shad_dp_q <= '0;
      pend_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      disp_q    <= disp_d;
      disp_dp_q <= disp_dp_d;
      shad_q    <= shad_d;
      shad_dp_q <= shad_dp_d;
      pend_q    <= pend_d;
    end
  end

`ifdef LEAD_ZERO_BLANK_EN
  logic [NDIG-1:0] lead_zero;
  logic            zero_run;

  // lead_zero[k] is set when digits NDIG-1..k are all zero; digit 0 is never suppressed.
  always_comb begin
    lead_zero = '0;
    zero_run  = 1'b1;
    for (int k = NDIG - 1; k > 0; k--) begin
      zero_run     = zero_run & (disp_q[4*k +: 4] == 4'h0);
      lead_zero[k] = zero_run;
    end
  end

  assign suppress = lead_zero[idx_q];
`else
  assign suppress = 1'b0;
`endif

  always_comb begin
    dig_n = '1;
    if ((32'(cnt_q) >= BLANK) && !suppress) begin
      dig_n[idx_q] = 1'b0;
    end
  end

  assign scan_if.dig_n      = dig_n;
  assign scan_if.nib_o      = disp_q[{idx_q, 2'b00} +: 4];
  assign scan_if.dp_n       = ~disp_dp_q[idx_q];
  assign scan_if.pend       = pend_q;
  assign scan_if.frame_tick = fb;

endmodule
